// File: rtl/bcd_event_counter_pkg.sv
// Shared display package: seven-segment patterns, blank pattern and BCD helpers.
// Segment order is g..a, MSB..LSB, active-low.
package bcd_event_counter_pkg;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  localparam logic [3:0] BcdMax = 4'd9;

  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] SegBlank = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = Seg0;
      4'd1:    seg = Seg1;
      4'd2:    seg = Seg2;
      4'd3:    seg = Seg3;
      4'd4:    seg = Seg4;
      4'd5:    seg = Seg5;
      4'd6:    seg = Seg6;
      4'd7:    seg = Seg7;
      4'd8:    seg = Seg8;
      4'd9:    seg = Seg9;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  // Out-of-range BCD digits saturate to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BcdMax) ? BcdMax : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit: up/down step with carry/borrow chaining, clamped parallel load.
module bcd_digit
  import bcd_event_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  dir_e       dir,
  input  logic       carry_in,
  output logic       carry_out,
  output logic [3:0] digit
);

  logic [3:0] digit_q, digit_d;
  logic       at_limit;

  always_comb begin
    at_limit = (dir == DirDown) ? (digit_q == 4'd0) : (digit_q == BcdMax);
    digit_d  = digit_q;
    if (at_limit) begin
      digit_d = (dir == DirDown) ? BcdMax : 4'd0;
    end else begin
      digit_d = (dir == DirDown) ? digit_q - 4'd1 : digit_q + 4'd1;
    end
  end

  assign carry_out = carry_in & at_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else if (load) begin
      digit_q <= bcd_clamp(load_val);
    end else if (carry_in) begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_event_counter.sv
// Multi-digit BCD up/down event counter with free-running tick prescaler and
// seven-segment decode with optional leading-zero blanking.
module bcd_event_counter
  import bcd_event_counter_pkg::*;
#(
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_en,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  tick,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic          wrap_q;
  logic          step;
  logic [DIGITS:0] carry;
  dir_e          dir;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q <= '0;
    end else if (presc_q == PrescMax) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign tick     = (presc_q == PrescMax);
  assign step     = tick & run;
  assign carry[0] = step;
  assign dir      = down ? DirDown : DirUp;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    bcd_digit u_digit (
      .clk       (CLOCK_50),
      .reset     (reset),
      .load      (load),
      .load_val  (load_val[4*g +: 4]),
      .dir       (dir),
      .carry_in  (carry[g]),
      .carry_out (carry[g+1]),
      .digit     (count_bcd[4*g +: 4])
    );
  end

  // A carry out of the top digit is exactly a full rollover/rollunder.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= ~load & carry[DIGITS];
    end
  end

  assign wrap = wrap_q;

  logic [3:0] d;
  logic       higher_zero;

  always_comb begin
    hex         = '1;
    d           = '0;
    higher_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      d           = count_bcd[4*k +: 4];
      higher_zero = higher_zero & (d == 4'd0);
      if (blank_en && (k != 0) && higher_zero) begin
        hex[7*k +: 7] = SegBlank;
      end else begin
        hex[7*k +: 7] = seg_decode(d);
      end
    end
  end

endmodule
